// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit path: FSM states, PID constants and
// the NRZI line helper.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam logic [7:0] NAK_PID      = 8'h5A;
  localparam logic [7:0] DATA1_PID    = 8'h4B;
  localparam int         EOP_SE0_BITS = 2;

  // NRZI: a 0 toggles the line, a 1 holds it.
  function automatic logic nrzi(input logic line, input logic b);
    return b ? line : ~line;
  endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// USB serial transmit back end: LSB-first serializer with bit stuffing, NRZI
// encoding, EOP generation and return to idle J on the D+/D- pair.
module usb_tx_encoder
  import usb_pkg::*;
#(
  parameter int BIT_CYCLES  = 8,
  parameter int STUFF_LIMIT = 6
) (
  input  logic       r_clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_d_plus,
  output logic       tx_d_minus,
  output logic       is_txing,
  output logic       underrun,
  output tx_state_e  dbg_state
);

  localparam int              CW        = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0]   CYC_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]      ONES_MAX  = 3'(STUFF_LIMIT);
  localparam logic [2:0]      SE0_LAST  = 3'(EOP_SE0_BITS - 1);

  tx_state_e     state_q;
  logic [6:0]    shift_q;
  logic          last_q;
  logic [2:0]    ones_q;
  logic [2:0]    bit_idx_q;
  logic [CW-1:0] cyc_q;
  logic          dp_q;
  logic          dm_q;
  logic          txing_q;

  logic       bit_end;
  logic       need_stuff;
  logic       byte_end;
  logic       dp_adv_d;
  logic       dp_load_d;
  logic [2:0] ones_adv_d;
  logic [2:0] ones_load_d;

  function automatic logic [2:0] ones_step(input logic [2:0] ones, input logic b);
    if (!b)              return 3'd0;
    if (ones == ONES_MAX) return ones;
    return ones + 3'd1;
  endfunction

  // Handshake: a byte transfers on the clock edge that ends a cycle with
  // tx_valid & tx_ready. tx_ready is a combinational strobe that only rises in
  // IDLE or on the final cycle of bit 7 (or its trailing stuff bit) of a
  // non-last byte, so the next byte's first bit follows with no line gap.
  always_comb begin
    bit_end     = (cyc_q == CYC_LAST);
    need_stuff  = (ones_q == ONES_MAX);
    byte_end    = ((state_q == ST_SHIFT) || (state_q == ST_STUFF)) && bit_end &&
                  !need_stuff && (bit_idx_q == 3'd7) && !last_q;
    tx_ready    = ~rst & tx_valid & ((state_q == ST_IDLE) | byte_end);
    underrun    = byte_end & ~tx_valid;
    dp_adv_d    = nrzi(dp_q, shift_q[0]);
    dp_load_d   = nrzi(dp_q, tx_byte[0]);
    ones_adv_d  = ones_step(ones_q, shift_q[0]);
    ones_load_d = ones_step(ones_q, tx_byte[0]);
  end

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      last_q    <= 1'b0;
      ones_q    <= '0;
      bit_idx_q <= '0;
      cyc_q     <= '0;
      dp_q      <= 1'b1;
      dm_q      <= 1'b0;
      txing_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tx_ready) begin
            state_q   <= ST_SHIFT;
            shift_q   <= tx_byte[7:1];
            last_q    <= tx_last;
            ones_q    <= {2'b00, tx_byte[0]};
            bit_idx_q <= '0;
            cyc_q     <= '0;
            dp_q      <= dp_load_d;
            dm_q      <= ~dp_load_d;
            txing_q   <= 1'b1;
          end
        end
        ST_SHIFT, ST_STUFF: begin
          cyc_q <= bit_end ? '0 : cyc_q + CW'(1);
          if (bit_end) begin
            if (need_stuff) begin
              state_q <= ST_STUFF;
              ones_q  <= '0;
              dp_q    <= ~dp_q;
              dm_q    <= dp_q;
            end else if (bit_idx_q != 3'd7) begin
              state_q   <= ST_SHIFT;
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              ones_q    <= ones_adv_d;
              dp_q      <= dp_adv_d;
              dm_q      <= ~dp_adv_d;
            end else if (tx_ready) begin
              state_q   <= ST_SHIFT;
              shift_q   <= tx_byte[7:1];
              last_q    <= tx_last;
              bit_idx_q <= '0;
              ones_q    <= ones_load_d;
              dp_q      <= dp_load_d;
              dm_q      <= ~dp_load_d;
            end else begin
              // Last byte finished, or the next byte was late: close the packet.
              state_q   <= ST_EOP_SE0;
              bit_idx_q <= '0;
              dp_q      <= 1'b0;
              dm_q      <= 1'b0;
            end
          end
        end
        ST_EOP_SE0: begin
          cyc_q <= bit_end ? '0 : cyc_q + CW'(1);
          if (bit_end) begin
            if (bit_idx_q == SE0_LAST) begin
              state_q   <= ST_EOP_J;
              bit_idx_q <= '0;
              dp_q      <= 1'b1;
              dm_q      <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        ST_EOP_J: begin
          cyc_q <= bit_end ? '0 : cyc_q + CW'(1);
          if (bit_end) begin
            state_q <= ST_IDLE;
            txing_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_d_plus  = dp_q;
  assign tx_d_minus = dm_q;
  assign is_txing   = txing_q;
  assign dbg_state  = state_q;

endmodule
